// File: rtl/fiat_25519_carry_chain.sv
// fiat_25519_carry_chain
// Carry-propagation and mod 2^255-19 reduction stage of the curve25519
// field multiplier. Ten unreduced 64-bit limb accumulations arrive one per
// beat. Each is added to the running carry and masked to 26/25 bits
// (even/odd limb). The final carry is folded into limb 0 as carry*19. The
// ten loose limbs are then streamed out as 32-bit words.
//
// Ports:
//   ap_clk, ap_rst      clock, asynchronous active-high reset
//   in_data/in_valid/in_ready     input limb stream (beat number = limb index)
//   out_data/out_idx/out_valid/out_ready  output limb stream
//   busy                high while folding or emitting
//   ovf                 sticky input-bound violation flag
//   dbg_state           current FSM state (0 ACCEPT, 1 FOLD, 2 EMIT)
//
// Handshake: a beat transfers on a rising edge where valid & ready are both
// high. A source holding valid may not change its data until the transfer.
// This block holds out_data/out_idx stable while out_valid & ~out_ready.
//
// Optional feature: define FIAT25519_CARRY_OVF_CHECK_EN to enable the ovf
// check. Without it, ovf is tied low.

module fiat_25519_carry_chain (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        ovf,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    FOLD   = 2'd1,
    EMIT   = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [39:0] carry_q;
  // 26 bits for every limb: limb 1 can grow to 26 bits after the fold.
  logic [25:0] buf_q [10];

  logic        in_fire;
  logic        out_fire;
  logic [64:0] t_sum;
  logic [25:0] limb_d;
  logic [39:0] carry_d;
  logic [45:0] t0;
  logic [25:0] buf1_d;

  assign in_ready  = (state_q == ACCEPT);
  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q != ACCEPT);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign dbg_state = state_q;
  // idx_q counts input beats in ACCEPT, so the index is masked outside EMIT.
  assign out_data  = out_valid ? {6'd0, buf_q[idx_q]} : 32'd0;
  assign out_idx   = out_valid ? idx_q : 4'd0;

  always_comb begin
    t_sum = {1'b0, in_data} + {25'd0, carry_q};
    // Odd limbs hold 25 bits. Even limbs hold 26 bits.
    if (idx_q[0]) begin
      limb_d  = {1'b0, t_sum[24:0]};
      carry_d = t_sum[64:25];
    end else begin
      limb_d  = t_sum[25:0];
      carry_d = {1'b0, t_sum[64:26]};
    end
    // 2^255 = 19 (mod p). The top carry re-enters at limb 0 scaled by 19.
    t0     = {20'd0, buf_q[0]} + ({6'd0, carry_q} * 46'd19);
    buf1_d = buf_q[1] + {6'd0, t0[45:26]};
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= ACCEPT;
      idx_q   <= 4'd0;
      carry_q <= 40'd0;
      for (int i = 0; i < 10; i++) buf_q[i] <= 26'd0;
    end else begin
      case (state_q)
        ACCEPT: begin
          if (in_fire) begin
            buf_q[idx_q] <= limb_d;
            carry_q      <= carry_d;
            if (idx_q == 4'd9) begin
              idx_q   <= 4'd0;
              state_q <= FOLD;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        FOLD: begin
          buf_q[0] <= t0[25:0];
          buf_q[1] <= buf1_d;
          carry_q  <= 40'd0;
          idx_q    <= 4'd0;
          state_q  <= EMIT;
        end
        EMIT: begin
          if (out_fire) begin
            if (idx_q == 4'd9) begin
              idx_q   <= 4'd0;
              state_q <= ACCEPT;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        default: begin
          idx_q   <= 4'd0;
          state_q <= ACCEPT;
        end
      endcase
    end
  end

`ifdef FIAT25519_CARRY_OVF_CHECK_EN
  logic ovf_q;
  logic beat_big;

  // The limb widths are only proven safe for inputs below 2^59.
  assign beat_big = |in_data[63:59];

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ovf_q <= 1'b0;
    end else if (in_fire) begin
      // The first beat of a frame restarts the flag.
      if (idx_q == 4'd0) ovf_q <= beat_big;
      else if (beat_big) ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fiat_25519_carry_chain.sv
module tb_fiat_25519_carry_chain;

  // ---------------- clock / reset ----------------
  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        ovf;
  logic [1:0]  dbg_state;

  always #5 ap_clk = ~ap_clk;

  fiat_25519_carry_chain dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [35:0] exp_q[$];
  logic [63:0] vin  [10];
  logic [31:0] vexp [10];
  bit          bp_en = 1'b0;
  logic        exp_ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic        stall_prev = 1'b0;
  logic [35:0] stall_val  = '0;

  always @(negedge ap_clk) begin
    if (ap_rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("stable", {out_idx, out_data}, stall_val);
      if (out_valid) check("in_ready_emit", {in_ready, busy}, 2'b01);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got %0h, expected no output", {out_idx, out_data});
        end else begin
          check("out", {out_idx, out_data}, exp_q.pop_front());
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_val  = {out_idx, out_data};
    end
  end

  // ---------------- output backpressure ----------------
  initial out_ready = 1'b1;
  always @(posedge ap_clk) begin
    #1;
    out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_vec();
    for (int i = 0; i < 10; i++) begin
      vin[i]  = 64'd0;
      vexp[i] = 32'd0;
    end
  endtask

  // Reference arithmetic on wide integers, straight from the field definition.
  task automatic model();
    logic [127:0] c, t, t0;
    int w;
    c = '0;
    for (int i = 0; i < 10; i++) begin
      w = (i % 2 == 1) ? 25 : 26;
      t = {64'd0, vin[i]} + c;
      vexp[i] = 32'(t % (128'd1 << w));
      c = t >> w;
    end
    t0 = {96'd0, vexp[0]} + 128'd19 * c;
    vexp[0] = 32'(t0 % (128'd1 << 26));
    vexp[1] = vexp[1] + 32'(t0 >> 26);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 1000) begin
      @(posedge ap_clk); #1;
      k++;
    end
    check("in_ready_wait", in_ready, 1);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(posedge ap_clk); #1;
      k++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge ap_clk); #1;
  endtask

  task automatic drive_frame(input bit gaps, input int chk_beat, input logic chk_val);
    wait_ready();
    for (int i = 0; i < 10; i++) exp_q.push_back({4'(i), vexp[i]});
    for (int i = 0; i < 10; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          @(posedge ap_clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = vin[i];
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
      if (i == chk_beat) check("ovf_beat", ovf, chk_val);
    end
    // FOLD cycle, then limb 0 presented in the following cycle.
    check("fold_cycle", {busy, out_valid, in_ready}, 3'b100);
    @(posedge ap_clk); #1;
    check("first_out", {out_valid, out_idx}, 5'b10000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
`ifdef FIAT25519_CARRY_OVF_CHECK_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    ap_rst   = 1'b1;
    in_valid = 1'b0;
    in_data  = 64'd0;
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out", {out_valid, out_idx, out_data}, 37'd0);
    check("rst_busy_ovf", {busy, ovf}, 2'b00);
    check("rst_state", dbg_state, 0);
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;

    // all zeros
    clear_vec();
    drive_frame(1'b0, -1, 1'b0);
    wait_drain();

    // 2^26+5 in limb 0: carry 1 into limb 1
    clear_vec();
    vin[0]  = (64'd1 << 26) + 64'd5;
    vexp[0] = 32'd5;
    vexp[1] = 32'd1;
    drive_frame(1'b0, -1, 1'b0);
    wait_drain();

    // 2^51 in limb 8: ripples through limb 9 to a fold carry of 1
    clear_vec();
    vin[8]  = 64'd1 << 51;
    vexp[0] = 32'd19;
    drive_frame(1'b0, -1, 1'b0);
    wait_drain();

    // 2^48-1 in limb 9: fold carry 2^23-1
    clear_vec();
    vin[9]  = 64'h0000_FFFF_FFFF_FFFF;
    vexp[9] = 32'd33554431;
    vexp[0] = 32'd25165805;
    vexp[1] = 32'd2;
    drive_frame(1'b0, -1, 1'b0);
    wait_drain();

    // out-of-bound input: 2^60 in limb 3 -> 2^35 carry -> 2^9 lands in limb 5
    clear_vec();
    vin[3]  = 64'd1 << 60;
    vexp[5] = 32'd512;
    drive_frame(1'b0, 3, exp_ovf);
    check("ovf_hold_fold", ovf, exp_ovf);
    wait_drain();
    check("ovf_hold_idle", ovf, exp_ovf);
    clear_vec();
    drive_frame(1'b0, 0, 1'b0);
    wait_drain();

    // random frames with input gaps and output backpressure
    bp_en = 1'b1;
    for (int f = 0; f < 300; f++) begin
      for (int i = 0; i < 10; i++) begin
        if (f % 4 == 0) vin[i] = {$urandom, $urandom};
        else            vin[i] = 64'($urandom) << $urandom_range(0, 27);
      end
      model();
      drive_frame(1'b1, -1, 1'b0);
    end
    wait_drain();
    bp_en = 1'b0;
    @(posedge ap_clk); #1;

    // reset while emitting limb 4
    clear_vec();
    for (int i = 0; i < 10; i++) begin
      vin[i]  = 64'(i + 1);
      vexp[i] = 32'(i + 1);
    end
    drive_frame(1'b0, -1, 1'b0);
    k = 0;
    while (!(out_valid && out_idx == 4'd4) && k < 50) begin
      @(posedge ap_clk); #1;
      k++;
    end
    check("abort_at_idx4", {out_valid, out_idx}, 5'b10100);
    #1;
    ap_rst = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out", {out_valid, out_idx, out_data}, 37'd0);
    check("abort_busy_ovf", {busy, ovf}, 2'b00);
    check("abort_left", exp_q.size(), 6);
    exp_q.delete();
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    clear_vec();
    drive_frame(1'b0, -1, 1'b0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
